latch_probe: RTL and testbench

Sequential stimulus/response tester for the on-die CMOS inverter/latch cell. It drives an 8-bit pattern serially, MSB first, onto the cell input pin. It samples the cell output pin back through a 2-flop synchroniser and checks each bit against the expected polarity. It reports errors, timeouts and response delay in clock cycles, and sits in the digital wrapper between ui_in/uo_out and the cell pins.

---
 rtl/latch_probe.sv | 191 +++++++++++++++++++
 tb/tb_latch_probe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_probe.sv
// Purpose: serial stimulus/response tester for the on-die inverter/latch cell.
// Latency: 5 cycles per bit for an ideal cell, done 41 cycles after start is accepted.
// Backpressure: none; start is taken only in IDLE and dropped otherwise, with no queueing.
//
// Ports:
//   clk, rst        single clock domain; synchronous active-high reset
//   start           1-cycle request, sampled only in IDLE
//   pattern_in      8-bit stimulus, driven MSB first, captured on an accepted start
//   mode            0 = inverting cell (expect ~bit), 1 = transparent latch (expect bit)
//   cell_out        asynchronous cell response, enters a 2-flop synchroniser
//   cell_drv        registered drive to the cell input; holds its last value after DONE
//   busy            high from the cycle after start acceptance until DONE exits
//   done            1-cycle pulse, visible together with the final results
//   pass            err_count==0, updated in DONE, held until the next accepted start
//   err_count       mismatching/timed-out bits, saturating at 15
//   max_delay       worst per-bit match delay in cycles (MAX_WAIT on timeout)
//   timeout         sticky per run; set if any bit times out
module latch_probe #(
  parameter int unsigned MAX_WAIT  = 12,
  parameter int unsigned CMP_START = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pattern_in,
  input  logic       mode,
  input  logic       cell_out,
  output logic       cell_drv,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [3:0] max_delay,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [3:0] CMP_START_C = 4'(CMP_START);

  state_t     state_q, state_d;
  logic [7:0] pattern_q, pattern_d;
  logic       mode_q, mode_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       cell_drv_q, cell_drv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_count_q, err_count_d;
  logic [3:0] max_delay_q, max_delay_d;
  logic       timeout_q, timeout_d;

  logic       exp_bit;
  logic       cmp_en;

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    wait_cnt_d  = wait_cnt_q;
    sync1_d     = cell_out;
    sync2_d     = sync1_q;
    cell_drv_d  = cell_drv_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    max_delay_d = max_delay_q;
    timeout_d   = timeout_q;

    exp_bit = mode_q ? pattern_q[idx_q] : ~pattern_q[idx_q];
    // The first CMP_START-1 wait cycles are the synchroniser still carrying
    // the response to the previous drive, so they are never compared.
    cmp_en  = (wait_cnt_q >= CMP_START_C);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pattern_d   = pattern_in;
          mode_d      = mode;
          err_count_d = 4'd0;
          max_delay_d = 4'd0;
          timeout_d   = 1'b0;
          pass_d      = 1'b0;
          idx_d       = 3'd7;
          busy_d      = 1'b1;
          state_d     = S_DRIVE;
        end
      end

      S_DRIVE: begin
        cell_drv_d = pattern_q[idx_q];
        wait_cnt_d = 4'd1;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (cmp_en && (sync2_q == exp_bit)) begin
          if (wait_cnt_q > max_delay_q) begin
            max_delay_d = wait_cnt_q;
          end
          state_d = S_NEXT;
        end else if (wait_cnt_q == MAX_WAIT_C) begin
          if (err_count_q != 4'hF) begin
            err_count_d = err_count_q + 4'd1;
          end
          timeout_d   = 1'b1;
          max_delay_d = MAX_WAIT_C;
          state_d     = S_NEXT;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      S_NEXT: begin
        if (idx_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - 3'd1;
          state_d = S_DRIVE;
        end
      end

      S_DONE: begin
        // done, pass and the falling busy all become visible on the same edge.
        done_d  = 1'b1;
        pass_d  = (err_count_q == 4'd0);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pattern_q   <= 8'd0;
      mode_q      <= 1'b0;
      idx_q       <= 3'd0;
      wait_cnt_q  <= 4'd0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cell_drv_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 4'd0;
      max_delay_q <= 4'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      wait_cnt_q  <= wait_cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cell_drv_q  <= cell_drv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      max_delay_q <= max_delay_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cell_drv  = cell_drv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign max_delay = max_delay_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_latch_probe.sv
// Scoreboard bench for latch_probe: stimulus pushes expected results per run,
// a monitor pops and compares them whenever done is presented.
// Several cell models (inverter, buffer, delayed inverter, stuck-at-0) are selectable.
module tb_latch_probe;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pattern_in;
  logic       mode;
  logic       cell_out;
  logic       cell_drv;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [3:0] max_delay;
  logic       timeout;

  always #5 clk = ~clk;

  latch_probe #(
    .MAX_WAIT (12),
    .CMP_START(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern_in(pattern_in),
    .mode      (mode),
    .cell_out  (cell_out),
    .cell_drv  (cell_drv),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .max_delay (max_delay),
    .timeout   (timeout)
  );

  // Posedge counter; read only at negedges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cell models: 0 inverter, 1 buffer, 2 inverter behind 5-flop delay line, 3 stuck at 0.
  int         model = 0;
  logic [4:0] dl = '1;
  always @(posedge clk) dl <= {dl[3:0], ~cell_drv};
  always_comb begin
    case (model)
      0:       cell_out = ~cell_drv;
      1:       cell_out = cell_drv;
      2:       cell_out = dl[4];
      default: cell_out = 1'b0;
    endcase
  end

  typedef struct packed {
    logic        pass;
    logic [3:0]  err;
    logic [3:0]  maxd;
    logic        tmo;
    logic [31:0] done_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_done   = 0;
  int   n_pushed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic p, input logic [3:0] e, input logic [3:0] md,
                          input logic t, input int dc);
    exp_t x;
    x = '{p, e, md, t, 32'(dc)};
    sb.push_back(x);
    n_pushed++;
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), e.done_cyc);
          check("pass", 32'(pass), 32'(e.pass));
          check("err_count", 32'(err_count), 32'(e.err));
          check("max_delay", 32'(max_delay), 32'(e.maxd));
          check("timeout", 32'(timeout), 32'(e.tmo));
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge (cyc == acc).
  task automatic do_start(input logic [7:0] p, input logic m, output int acc);
    start      = 1'b1;
    pattern_in = p;
    mode       = m;
    acc        = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int         acc;
    logic [7:0] p1;
    rst        = 1'b1;
    start      = 1'b0;
    pattern_in = 8'h00;
    mode       = 1'b0;
    model      = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cell_drv", 32'(cell_drv), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_maxd", 32'(max_delay), 32'd0);
    check("rst_tmo", 32'(timeout), 32'd0);
    repeat (5) @(negedge clk);

    // 1: ideal inverter, 0xA5
    p1 = 8'hA5;
    do_start(p1, 1'b0, acc);
    check("s1_busy", 32'(busy), 32'd1);
    push_exp(1'b1, 4'd0, 4'd3, 1'b0, acc + 41);
    for (int j = 0; j < 8; j++) begin
      wait_until(acc + 2 + 5 * j);
      check($sformatf("s1_drv_bit%0d", 7 - j), 32'(cell_drv), 32'(p1[7 - j]));
    end
    wait_drain(200);
    check("s1_pass_held", 32'(pass), 32'd1);
    check("s1_drv_holds", 32'(cell_drv), 32'd1);

    // 2: buffer with inverting expectation, every bit times out
    model = 1;
    repeat (8) @(negedge clk);
    do_start(8'h3C, 1'b0, acc);
    check("s2_pass_cleared", 32'(pass), 32'd0);
    push_exp(1'b0, 4'd8, 4'd12, 1'b1, acc + 113);
    wait_drain(300);

    // 3: inverter behind a 5-cycle delay line
    model = 2;
    repeat (10) @(negedge clk);
    do_start(8'h55, 1'b0, acc);
    check("s3_tmo_cleared", 32'(timeout), 32'd0);
    check("s3_err_cleared", 32'(err_count), 32'd0);
    push_exp(1'b1, 4'd0, 4'd8, 1'b0, acc + 76);
    wait_drain(300);

    // 4: stuck-at-0, transparent mode, 0xF0
    model = 3;
    repeat (10) @(negedge clk);
    do_start(8'hF0, 1'b1, acc);
    push_exp(1'b0, 4'd4, 4'd12, 1'b1, acc + 77);
    wait_drain(300);

    // 5: reset during WAIT of bit 4 (buffer model so errors have accumulated)
    model = 1;
    repeat (10) @(negedge clk);
    do_start(8'hFF, 1'b0, acc);
    wait_until(acc + 48);
    check("s5_err_mid", 32'(err_count), 32'd3);
    check("s5_drv_mid", 32'(cell_drv), 32'd1);
    wait_until(acc + 49);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_cell_drv", 32'(cell_drv), 32'd0);
    check("s5_err", 32'(err_count), 32'd0);
    check("s5_maxd", 32'(max_delay), 32'd0);
    check("s5_tmo", 32'(timeout), 32'd0);
    check("s5_done", 32'(done), 32'd0);
    repeat (60) @(negedge clk);
    model = 0;
    repeat (10) @(negedge clk);
    do_start(8'hA5, 1'b0, acc);
    push_exp(1'b1, 4'd0, 4'd3, 1'b0, acc + 41);
    wait_drain(200);

    // 6: start pulses while busy and during DONE are dropped
    repeat (5) @(negedge clk);
    do_start(8'h5A, 1'b0, acc);
    push_exp(1'b1, 4'd0, 4'd3, 1'b0, acc + 41);
    wait_until(acc + 10);
    start = 1'b1; pattern_in = 8'h00; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(acc + 40);
    start = 1'b1; pattern_in = 8'h00; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("s6_busy_after", 32'(busy), 32'd0);
    wait_drain(100);

    repeat (20) @(negedge clk);
    check("done_count", 32'(n_done), 32'(n_pushed));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
